instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters: WIDTH=16 (instruction word width), OP_BITS=4 (opcode field width), REG_BITS=4 (register index width), IMM_BITS=8 (immediate width), ADDR_BITS=10 (program-memory address width), CNT_BITS=11 (word-count width).
REQ-002 One clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  begin a load session; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_BITS  first program-memory address; latched on accepted start.
REQ-007 word_count  in  CNT_BITS  number of instructions in the session; latched on accepted start.
REQ-008 abort  in  1  synchronous session cancel.
REQ-009 in_valid / in_ready  in / out  1 / 1  field-bundle handshake.
REQ-010 op_code, a_index, ext_op_code, b_index  in  OP_BITS, REG_BITS, OP_BITS, REG_BITS  instruction fields.
REQ-011 immediate  in  IMM_BITS  immediate or displacement field.
REQ-012 mem_we  out  1  write request, held until mem_ready.
REQ-013 mem_ready  in  1  memory accepts the write this cycle.
REQ-014 mem_addr / mem_wdata  out  ADDR_BITS / WIDTH  write address and encoded word.
REQ-015 busy / done  out  1 / 1  session active / one-cycle completion pulse.
REQ-016 words_written  out  CNT_BITS  writes completed in the current or last session.

Function
REQ-017 Encoding: op_code[1:0]!=2'b00 or op_code==4'b1100 -> {op_code, a_index, immediate}; otherwise -> {op_code, a_index, ext_op_code, b_index}.
REQ-018 Encoded words round-trip exactly through the team's instruction-field decoder (op [15:12], A [11:8], ext [7:4], imm [7:0], B [3:0]).
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE + start + word_count>0 -> RUN; latch base_addr into the address counter; clear words_written and accepted count.
REQ-021 IDLE + start + word_count==0 -> DONE; no memory writes.
REQ-022 start outside IDLE is ignored.
REQ-023 in_ready=1 only in RUN, with the 2-entry FIFO not full and accepted < word_count; in_ready is independent of in_valid.
REQ-024 On in_valid&&in_ready the encoded word is pushed; a push on a full FIFO never occurs, including when a pop occurs in the same cycle.
REQ-025 mem_we = FIFO non-empty; mem_wdata = FIFO head; mem_addr = address counter; first mem_we no earlier than the cycle after the accepting handshake.
REQ-026 mem_we&&mem_ready pops the FIFO, increments mem_addr modulo 2^ADDR_BITS (wraps 1023->0), and increments words_written.
REQ-027 Simultaneous push and pop keep the occupancy unchanged and preserve order.
REQ-028 RUN -> DRAIN when accepted reaches word_count.
REQ-029 DRAIN -> DONE when the FIFO is empty.
REQ-030 DONE: done=1 for exactly one cycle, then -> IDLE; words_written holds its value until the next accepted start.
REQ-031 busy=1 in RUN and DRAIN.
REQ-032 abort in RUN or DRAIN -> IDLE next cycle: FIFO flushed, mem_we=0, no done pulse, words_written holds its value; abort has priority over every other transition.

Reset
REQ-033 rst_n low asynchronously forces: IDLE, FIFO empty, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, words_written=0.
REQ-034 Reset asserted mid-session discards all pending words; no write completes after reset assertion.

Verification
REQ-035 base_addr=0x010, word_count=3, fields {op=0000,A=3,ext=0101,B=7}, {op=0101,A=2,imm=0x7F}, {op=1100,A=1,imm=0xFE}, mem_ready=1 -> writes 0x0357@0x010, 0x527F@0x011, 0xC1FE@0x012; done pulses once; words_written=3.
REQ-036 word_count=4, mem_ready=0 for 10 cycles, in_valid=1 continuously -> in_ready falls after 2 accepts, mem_addr/mem_wdata stable; on mem_ready=1 all 4 written in order.
REQ-037 base_addr=0x3FF, word_count=2 -> writes at 0x3FF then 0x000.
REQ-038 start with word_count=0 -> done one cycle later, mem_we never asserted, words_written=0.
REQ-039 abort after 1 of 5 writes -> IDLE next cycle, mem_we=0, no done pulse, words_written=1; a following start operates normally.
REQ-040 rst_n pulsed low with 2 words queued -> all outputs at reset values immediately, no further writes.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Accepts instruction field bundles over a valid/ready handshake, packs each
//   bundle into a WIDTH-bit instruction word, buffers up to two words and
//   writes them to consecutive program-memory addresses.  A session is opened
//   with start (base address + word count) and closes with a one-cycle done
//   pulse, or is cancelled with abort.
//
//   Handshake rules (both interfaces):
//     - A transfer happens on a rising clock edge where valid and ready are
//       both 1.  Ready never depends on valid in the same cycle.  Once valid
//       is raised, it stays up and the payload stays stable until the
//       transfer.
//     - Field side:  in_valid (source) / in_ready (this block).
//     - Memory side: mem_we (this block, acts as valid) / mem_ready (memory).
//
//   Word formats:
//     immediate form: {op, A, imm}
//       used when op[1:0] != 0 or op == 4'b1100
//     register form:  {op, A, ext, B}
//       used otherwise
//   Field positions: op [15:12], A [11:8], ext [7:4], imm [7:0], B [3:0].
//
//   dbg_state exposes the FSM state:
//     0 = IDLE, 1 = RUN, 2 = DRAIN, 3 = DONE
// -----------------------------------------------------------------------------
module instr_encoder #(
   parameter int WIDTH     = 16,
   parameter int OP_BITS   = 4,
   parameter int REG_BITS  = 4,
   parameter int IMM_BITS  = 8,
   parameter int ADDR_BITS = 10,
   parameter int CNT_BITS  = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // session control
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] base_addr,
   input  logic [CNT_BITS-1:0]  word_count,
   input  logic                 abort,
   // field bundle
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OP_BITS-1:0]   op_code,
   input  logic [REG_BITS-1:0]  a_index,
   input  logic [OP_BITS-1:0]   ext_op_code,
   input  logic [REG_BITS-1:0]  b_index,
   input  logic [IMM_BITS-1:0]  immediate,
   // program-memory write port
   output logic                 mem_we,
   input  logic                 mem_ready,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [WIDTH-1:0]     mem_wdata,
   // status
   output logic                 busy,
   output logic                 done,
   output logic [CNT_BITS-1:0]  words_written,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // FSM
   state_t r_state;
   state_t w_next_state;

   // session counters
   logic [ADDR_BITS-1:0] r_addr;
   logic [CNT_BITS-1:0]  r_word_count;
   logic [CNT_BITS-1:0]  r_accepted;
   logic [CNT_BITS-1:0]  r_words_written;

   // two-entry word FIFO
   logic [WIDTH-1:0] r_fifo [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;

   // combinational helpers
   logic             w_imm_form;
   logic [WIDTH-1:0] w_encoded;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_room;
   logic             w_in_ready;
   logic             w_push;
   logic             w_pop;
   logic             w_start_ok;
   logic             w_abort;
   logic             w_last_push;
   logic             w_busy;
   logic             w_done;

   // Pack the incoming fields into one instruction word.
   always_comb begin
      w_imm_form = (op_code[1:0] != 2'b00) || (op_code == OP_BITS'(4'b1100));
      if (w_imm_form) begin
         w_encoded = {op_code, a_index, immediate};
      end else begin
         w_encoded = {op_code, a_index, ext_op_code, b_index};
      end
   end

   // Handshake and session qualifiers derived from registered state only.
   always_comb begin
      w_fifo_full  = (r_count == 2'd2);
      w_fifo_empty = (r_count == 2'd0);
      w_room       = (r_accepted < r_word_count);
      w_in_ready   = (r_state == S_RUN) && !w_fifo_full && w_room;
      // in_ready is already low when the FIFO is full, so a push can never
      // land on a full FIFO, even when a pop happens in the same cycle.
      w_push       = in_valid && w_in_ready;
      w_pop        = !w_fifo_empty && mem_ready;
      w_start_ok   = (r_state == S_IDLE) && start;
      w_abort      = abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
      w_last_push  = w_push && ((r_accepted + CNT_BITS'(1)) == r_word_count);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic; abort overrides every other transition.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (word_count != '0) begin
                  w_next_state = S_RUN;
               end else begin
                  w_next_state = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               w_next_state = S_IDLE;
            end else if (w_last_push) begin
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               w_next_state = S_IDLE;
            end else if (w_fifo_empty) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // FSM outputs (Moore).
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_RUN:   w_busy = 1'b1;
         S_DRAIN: w_busy = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: begin
            w_busy = 1'b0;
            w_done = 1'b0;
         end
      endcase
   end

   // Session bookkeeping: latch parameters on start, count accepts and
   // completed writes. A write accepted by memory in the abort cycle did
   // happen, so it is still counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr          <= '0;
         r_word_count    <= '0;
         r_accepted      <= '0;
         r_words_written <= '0;
      end else if (w_start_ok) begin
         r_addr          <= base_addr;
         r_word_count    <= word_count;
         r_accepted      <= '0;
         r_words_written <= '0;
      end else begin
         if (w_push) begin
            r_accepted <= r_accepted + CNT_BITS'(1);
         end
         if (w_pop) begin
            // address wraps naturally at 2^ADDR_BITS
            r_addr          <= r_addr + ADDR_BITS'(1);
            r_words_written <= r_words_written + CNT_BITS'(1);
         end
      end
   end

   // FIFO pointers and occupancy; abort flushes everything queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (w_abort) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; cleared on reset so mem_wdata reads zero afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
      end else if (w_push && !w_abort) begin
         r_fifo[r_wr_ptr] <= w_encoded;
      end
   end

   // Output drive.
   always_comb begin
      in_ready      = w_in_ready;
      mem_we        = !w_fifo_empty;
      mem_addr      = r_addr;
      mem_wdata     = r_fifo[r_rd_ptr];
      busy          = w_busy;
      done          = w_done;
      words_written = r_words_written;
      dbg_state     = r_state;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed scenarios followed by randomized sessions. A reference model
//   turns each accepted field bundle into an expected {address, word} pair
//   using plain arithmetic. A write monitor compares every memory write
//   against the head of that expected queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_encoder;

   localparam int WIDTH     = 16;
   localparam int ADDR_BITS = 10;
   localparam int CNT_BITS  = 11;
   localparam int EW        = ADDR_BITS + WIDTH;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic                 start;
   logic [ADDR_BITS-1:0] base_addr;
   logic [CNT_BITS-1:0]  word_count;
   logic                 abort;
   logic                 in_valid;
   logic                 in_ready;
   logic [3:0]           op_code;
   logic [3:0]           a_index;
   logic [3:0]           ext_op_code;
   logic [3:0]           b_index;
   logic [7:0]           immediate;
   logic                 mem_we;
   logic                 mem_ready;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [WIDTH-1:0]     mem_wdata;
   logic                 busy;
   logic                 done;
   logic [CNT_BITS-1:0]  words_written;
   logic [1:0]           dbg_state;

   instr_encoder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .base_addr     (base_addr),
      .word_count    (word_count),
      .abort         (abort),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .op_code       (op_code),
      .a_index       (a_index),
      .ext_op_code   (ext_op_code),
      .b_index       (b_index),
      .immediate     (immediate),
      .mem_we        (mem_we),
      .mem_ready     (mem_ready),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .busy          (busy),
      .done          (done),
      .words_written (words_written),
      .dbg_state     (dbg_state)
   );

   // ---------------- memory-ready source ----------------
   logic force_ready;
   logic rand_ready;
   logic r_rand_bit;
   always @(posedge clk) begin
      #1;
      r_rand_bit = ($urandom_range(0, 3) != 0);
   end
   assign mem_ready = rand_ready ? r_rand_bit : force_ready;

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int n_checks  = 0;
   int n_fail    = 0;
   int n_writes  = 0;
   int done_cnt  = 0;
   int m_base    = 0;
   int m_k       = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference encoding straight from the format rules.
   function automatic int ref_encode(input int op, input int a, input int ext,
                                     input int b, input int imm);
      if ((op % 4) != 0 || op == 12) begin
         return op * 4096 + a * 256 + imm;
      end
      return op * 4096 + a * 256 + ext * 16 + b;
   endfunction

   // Write monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n && mem_we && mem_ready) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(mem_we), 32'(0));
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e[EW-1:WIDTH]));
            chk("wr_data", 32'(mem_wdata), 32'(e[WIDTH-1:0]));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks start and end 1 ns after a rising edge.
   task automatic start_session(input int base, input int wc);
      base_addr  = ADDR_BITS'(base);
      word_count = CNT_BITS'(wc);
      start      = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      m_base = base;
      m_k    = 0;
   endtask

   task automatic send_word(input int op, input int a, input int ext, input int b, input int imm);
      bit got = 0;
      op_code     = 4'(op);
      a_index     = 4'(a);
      ext_op_code = 4'(ext);
      b_index     = 4'(b);
      immediate   = 8'(imm);
      in_valid    = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            @(posedge clk); #1;
            break;
         end
      end
      chk("accept_seen", 32'(got), 32'(1));
      if (got) begin
         exp_q.push_back({ADDR_BITS'((m_base + m_k) % 1024), WIDTH'(ref_encode(op, a, ext, b, imm))});
         m_k++;
      end else begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_random_word();
      send_word($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 255));
   endtask

   task automatic wait_done();
      bit got = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      chk("done_seen", 32'(got), 32'(1));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'(0));
      chk("idle_after_done", 32'(dbg_state), 32'(0));
      @(posedge clk); #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d0;
      int wc;
      int exp_data0;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; abort = 1'b0;
      in_valid = 1'b0; op_code = '0; a_index = '0; ext_op_code = '0; b_index = '0;
      immediate = '0; force_ready = 1'b0; rand_ready = 1'b0;

      // reset values
      #12;
      chk("rst_state", 32'(dbg_state), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_ww", 32'(words_written), 32'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // basic session: three words, one of each format case
      force_ready = 1'b1;
      d0 = done_cnt;
      start_session(16, 3);
      send_word(0, 3, 5, 7, 0);
      send_word(5, 2, 0, 0, 127);
      send_word(12, 1, 0, 0, 254);
      wait_done();
      chk("t1_ww", 32'(words_written), 32'(3));
      chk("t1_q_empty", 32'(exp_q.size()), 32'(0));
      chk("t1_done_once", 32'(done_cnt - d0), 32'(1));

      // back-pressure: memory stalls for 10 cycles
      force_ready = 1'b0;
      start_session(200, 4);
      send_word(0, 1, 2, 3, 0);
      send_word(9, 4, 0, 0, 85);
      exp_data0 = ref_encode(0, 1, 2, 3, 0);
      op_code = 4'd4; a_index = 4'd6; ext_op_code = 4'd7; b_index = 4'd8; immediate = 8'd0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'(0));
         chk("bp_mem_we", 32'(mem_we), 32'(1));
         chk("bp_addr", 32'(mem_addr), 32'(200));
         chk("bp_wdata", 32'(mem_wdata), 32'(exp_data0));
      end
      @(posedge clk); #1;
      force_ready = 1'b1;
      send_word(4, 6, 7, 8, 0);
      send_word(14, 15, 0, 0, 1);
      wait_done();
      chk("t2_ww", 32'(words_written), 32'(4));
      chk("t2_q_empty", 32'(exp_q.size()), 32'(0));

      // address wrap
      start_session(1023, 2);
      send_word(3, 9, 0, 0, 17);
      send_word(8, 10, 11, 12, 0);
      wait_done();
      chk("t3_ww", 32'(words_written), 32'(2));
      chk("t3_q_empty", 32'(exp_q.size()), 32'(0));

      // zero-length session
      d0 = done_cnt;
      start_session(5, 0);
      @(negedge clk);
      chk("zero_done", 32'(done), 32'(1));
      chk("zero_busy", 32'(busy), 32'(0));
      chk("zero_mem_we", 32'(mem_we), 32'(0));
      @(negedge clk);
      chk("zero_done_drop", 32'(done), 32'(0));
      chk("zero_ww", 32'(words_written), 32'(0));
      chk("zero_done_once", 32'(done_cnt - d0), 32'(1));
      @(posedge clk); #1;

      // abort after one completed write
      start_session(300, 5);
      send_word(1, 1, 0, 0, 1);
      @(posedge clk); #1;
      force_ready = 1'b0;
      send_word(2, 2, 0, 0, 2);
      d0 = done_cnt;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("abort_state", 32'(dbg_state), 32'(0));
      chk("abort_mem_we", 32'(mem_we), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_in_ready", 32'(in_ready), 32'(0));
      chk("abort_ww", 32'(words_written), 32'(1));
      idle_cycles(3);
      chk("abort_no_done", 32'(done_cnt - d0), 32'(0));
      chk("abort_ww_hold", 32'(words_written), 32'(1));
      force_ready = 1'b1;
      start_session(40, 2);
      send_word(7, 3, 0, 0, 99);
      send_word(0, 4, 4, 4, 0);
      wait_done();
      chk("post_abort_ww", 32'(words_written), 32'(2));
      chk("post_abort_q", 32'(exp_q.size()), 32'(0));

      // reset mid-session with two words queued
      force_ready = 1'b0;
      start_session(77, 4);
      send_word(6, 6, 0, 0, 6);
      send_word(0, 7, 7, 7, 0);
      d0 = n_writes;
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_state", 32'(dbg_state), 32'(0));
      chk("mid_rst_mem_we", 32'(mem_we), 32'(0));
      chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
      chk("mid_rst_addr", 32'(mem_addr), 32'(0));
      chk("mid_rst_wdata", 32'(mem_wdata), 32'(0));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_ww", 32'(words_written), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      force_ready = 1'b1;
      idle_cycles(5);
      chk("mid_rst_no_writes", 32'(n_writes - d0), 32'(0));
      chk("mid_rst_we_after", 32'(mem_we), 32'(0));

      // randomized sessions with random memory stalls and input gaps
      rand_ready = 1'b1;
      for (int s = 0; s < 20; s++) begin
         wc = $urandom_range(1, 6);
         d0 = done_cnt;
         start_session($urandom_range(0, 1023), wc);
         for (int k = 0; k < wc; k++) begin
            idle_cycles($urandom_range(0, 2));
            send_random_word();
         end
         wait_done();
         chk("rand_ww", 32'(words_written), 32'(wc));
         chk("rand_q_empty", 32'(exp_q.size()), 32'(0));
         chk("rand_done_once", 32'(done_cnt - d0), 32'(1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
